dmem_responder: RTL and testbench

Data-memory responder serving load/store requests from the memory-access stage of the pipelined core. Accepts one request at a time over a valid/ready handshake, applies a fixed configurable wait-state latency, then returns a one-cycle response pulse with load data or store completion. It sits between the memory-access stage and the data storage, and replaces the ad-hoc `data_out_v`/`data_out` path with a defined protocol. It handles byte/half/word sizing, load sign extension and error reporting.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and lane-mask helper for dmem_responder
package dmem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Width of the wait-state down-counter (covers WAIT_CYCLES 0..15)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Byte-enable pattern for an access of the given size at an aligned lane offset
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM with byte-write mask and registered read
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Masked byte writes; read returns the pre-write word (only one of the two is used per access)
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with fixed wait states; DMEM_MISALIGN_CHECK_EN makes misaligned half/word accesses fault
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_v,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_v,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [31:0]      r_wdata;

  logic        w_hs;
  logic [31:0] w_a_addr;
  logic        w_a_we;
  logic [1:0]  w_a_size;
  logic [31:0] w_a_wdata;
  logic [1:0]  w_off;
  logic        w_misalign;
  logic        w_oob;
  logic        w_err;
  logic        w_ram_en;
  logic        w_ram_we;
  logic [3:0]  w_be;
  logic [31:0] w_wrep;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_hs      = req_v && req_ready;

  // With zero wait states the array is accessed on the handshake edge itself, so the
  // access fields come straight from the request; otherwise from the latched copy.
  assign w_a_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_a_we    = (r_state == ST_IDLE) ? req_we    : r_we;
  assign w_a_size  = (r_state == ST_IDLE) ? req_size  : r_size;
  assign w_a_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

  // Lane offset with half/word forced to natural alignment
  always_comb begin
    w_off = w_a_addr[1:0];
    case (w_a_size)
      SIZE_H:  w_off = {w_a_addr[1], 1'b0};
      SIZE_W:  w_off = 2'b00;
      default: w_off = w_a_addr[1:0];
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = ((w_a_size == SIZE_H) && w_a_addr[0]) ||
                      ((w_a_size == SIZE_W) && (w_a_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_oob = ({2'b00, w_a_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_err = w_oob || (w_a_size == SIZE_RSVD) || w_misalign;

  // The array is touched only on the edge that enters RESP; reset suppresses it
  assign w_ram_en = !rst && (((r_state == ST_IDLE) && w_hs && (WAIT_CYCLES == 0)) ||
                             ((r_state == ST_WAIT) && (r_cnt == '0)));
  assign w_ram_we = w_a_we && !w_err;
  assign w_be     = lane_mask(w_a_size, w_off);

  // Replicate right-aligned store data into every lane so the mask picks the right one
  always_comb begin
    w_wrep = w_a_wdata;
    case (w_a_size)
      SIZE_B:  w_wrep = {4{w_a_wdata[7:0]}};
      SIZE_H:  w_wrep = {2{w_a_wdata[15:0]}};
      default: w_wrep = w_a_wdata;
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_be    (w_be),
    .i_addr  (w_a_addr[AW+1:2]),
    .i_wdata (w_wrep),
    .o_rdata (w_ram_rdata)
  );

  // Request sequencing: IDLE -> (WAIT) -> RESP -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_cnt   <= WAIT_LD;
            r_state <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the request fields on the handshake
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_addr  <= req_addr;
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_wdata <= req_wdata;
    end
  end

  assign w_lane = w_ram_rdata >> {w_off, 3'b000};

  // Sign/zero extension of the selected lane
  always_comb begin
    w_ext = w_ram_rdata;
    case (r_size)
      SIZE_B:  w_ext = r_uns ? {24'h0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
      SIZE_H:  w_ext = r_uns ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_ext = w_ram_rdata;
    endcase
  end

  assign rsp_v     = (r_state == ST_RESP) && !rst;
  assign rsp_err   = rsp_v && w_err;
  assign rsp_rdata = (rsp_v && !w_err && !r_we) ? w_ext : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized scoreboard bench for dmem_responder at 0 and 3 wait states
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WC[2] = '{0, 3};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic [1:0]  rst, req_v, req_ready, req_we, req_uns, rsp_v, rsp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata[2];
  logic [31:0] rsp_rdata[2];
  logic [1:0]  req_size [2];

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_hs[2] = '{-1, -1};
  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  logic [7:0] mb [2][4*DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_v(req_v[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_we(req_we[0]), .req_size(req_size[0]),
    .req_unsigned(req_uns[0]), .req_wdata(req_wdata[0]),
    .rsp_v(rsp_v[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .req_v(req_v[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_we(req_we[1]), .req_size(req_size[1]),
    .req_unsigned(req_uns[1]), .req_wdata(req_wdata[1]),
    .rsp_v(rsp_v[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s inst%0d: got %h, required %h", name, k, act, req);
    end
  endtask

  // Byte-addressed reference memory; returns what a correct responder must answer
  task automatic model(input int k, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] a;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = (sz == 2'b11) || (addr >= 32'(4*DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
    if (addr % n != 0) err = 1'b1;
`endif
    a  = addr - (addr % n);
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[k][a+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd = rd | (32'(mb[k][a+i]) << (8*i));
        if (!uns && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      end
    end
  endtask

  task automatic issue(input int k, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit push, input bit b2b);
    exp_t e;
    bit done;
    done = 0;
    @(negedge clk);
    req_v[k] = 1'b1; req_we[k] = we; req_size[k] = sz; req_uns[k] = uns;
    req_addr[k] = addr; req_wdata[k] = wd;
    for (int t = 0; t < 40 && !done; t++) begin
      if (t > 0) @(negedge clk);
      if (req_ready[k]) begin
        done = 1;
        if (b2b && last_hs[k] >= 0) chk("throughput", k, 32'(cyc - last_hs[k]), 32'(WC[k] + 2));
        last_hs[k] = cyc;
        if (push) begin
          model(k, we, sz, uns, addr, wd, e.rdata, e.err);
          e.cyc = cyc + WC[k] + 1;
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout inst%0d: got req_ready=0 for 40 cycles, required 1", k);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int k, input int n);
    @(negedge clk);
    req_v[k] = 1'b0;
    last_hs[k] = -1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rsp(input int k, input exp_t e);
    chk("rsp_rdata", k, rsp_rdata[k], e.rdata);
    chk("rsp_err", k, 32'(rsp_err[k]), 32'(e.err));
    chk("rsp_latency", k, 32'(cyc), 32'(e.cyc));
  endtask

  // Scoreboard monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rsp_v[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_rsp inst%0d: got rsp_v=1, required no response", k);
        end else begin
          mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check_rsp(k, mon_e);
        end
      end
    end
  end

  task automatic run_inst(input int k);
    logic [31:0] a, wd;
    logic [1:0]  sz;
    // preload words 0..63 and the last word, with req_v held high throughout
    for (int w = 0; w < 64; w++) issue(k, 1'b1, 2'b10, 1'b0, 32'(w*4), $urandom, 1, 1);
    issue(k, 1'b1, 2'b10, 1'b0, 32'hFFC, $urandom, 1, 1);
    idle(k, 2);
    // directed cases
    issue(k, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1, 0);
    issue(k, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 0);
    issue(k, 1'b1, 2'b00, 1'b0, 32'h21, 32'hABCD_1280, 1, 0);
    issue(k, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1, 0);
    issue(k, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1, 0);
    issue(k, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 0);
    issue(k, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 0);
    issue(k, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h5555_AAAA, 1, 0);
    issue(k, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1, 0);
    issue(k, 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 1, 0);
    issue(k, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 1, 0);
    issue(k, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1, 0);
    issue(k, 1'b1, 2'b01, 1'b0, 32'h6, 32'h7777_9234, 1, 0);
    issue(k, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 1, 0);
    issue(k, 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 1, 0);
    issue(k, 1'b1, 2'b11, 1'b0, 32'h8, 32'hFFFF_FFFF, 1, 0);
    issue(k, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1, 0);
    idle(k, 1);
    // randomized mix
    for (int i = 0; i < 150; i++) begin
      a  = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      wd = $urandom;
      issue(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd, 1, 0);
      if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 3));
    end
    idle(k, WC[k] + 3);
  endtask

  initial begin
    rst = 2'b11; req_v = 2'b00; req_we = 2'b00; req_uns = 2'b00;
    for (int k = 0; k < 2; k++) begin
      req_addr[k] = 32'h0; req_wdata[k] = 32'h0; req_size[k] = 2'b00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", k, 32'(req_ready[k]), 32'h0);
      chk("reset_rsp_v", k, 32'(rsp_v[k]), 32'h0);
      chk("reset_rsp_rdata", k, rsp_rdata[k], 32'h0);
      chk("reset_rsp_err", k, 32'(rsp_err[k]), 32'h0);
    end
    @(posedge clk); #1 rst = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("post_reset_ready", k, 32'(req_ready[k]), 32'h1);

    run_inst(0);
    run_inst(1);

    // store dropped by reset in its second wait cycle must not commit
    issue(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0BAD_F00D, 0, 0);
    #1 req_v[1] = 1'b0;
    @(posedge clk); #1 rst[1] = 1'b1;
    @(negedge clk);
    chk("midreq_rst_ready", 1, 32'(req_ready[1]), 32'h0);
    chk("midreq_rst_rsp_v", 1, 32'(rsp_v[1]), 32'h0);
    @(posedge clk); #1 rst[1] = 1'b0;
    @(negedge clk);
    chk("after_rst_ready", 1, 32'(req_ready[1]), 32'h1);
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, 0);
    idle(1, 8);

    chk("q0_drained", 0, 32'(q0.size()), 32'h0);
    chk("q1_drained", 1, 32'(q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end

endmodule
